// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for the EX stage (DIV / DIVU).
//   HI takes the remainder and LO takes the quotient, packed as
//   result_o = {remainder, quotient}.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i in IDLE
//   opdata1_i     dividend, sampled in IDLE when a request is accepted
//   opdata2_i     divisor, sampled in IDLE when a request is accepted
//   start_i       request; held high by EX until it has consumed ready_o
//   annul_i       flush; aborts any in-flight or completed division
//   result_o      {remainder, quotient}; forced to zero whenever ready_o=0
//   ready_o       result valid
//   dbg_state_o   current FSM state (0 IDLE, 1 BYZERO, 2 ON, 3 END)
//
// Handshake
//   A request is accepted on a rising edge in IDLE with start_i=1 and
//   annul_i=0. start_i acts as a level "still wanted" signal: if it drops (or
//   annul_i rises) before the result is consumed, the division is discarded
//   and the unit returns to IDLE. ready_o stays high, with result_o stable,
//   for as long as start_i is held in END; the edge that sees start_i low
//   returns the unit to IDLE and clears both outputs. A new request is only
//   taken from IDLE, so start_i must be low for at least one edge between
//   divisions.
//
// Timing
//   Accept at edge k. The ON state runs WIDTH iterations on edges k+1..k+WIDTH
//   and moves to END with the final iteration. The sign fix-up and output
//   register load happen on the first edge in END, so ready_o rises after
//   edge k+WIDTH+1. A zero divisor goes IDLE->BYZERO->END, so ready_o rises
//   after edge k+2.
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic [1:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH-1:0]     dvd_q,     dvd_d;      // |dividend|, shifted left one bit per iteration
    logic [WIDTH-1:0]     dsr_q,     dsr_d;      // |divisor|
    logic [WIDTH-1:0]     rem_q,     rem_d;      // partial remainder
    logic [WIDTH-1:0]     quo_q,     quo_d;      // quotient bits, shifted in at the LSB
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 ready_q,   ready_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;

    // One restoring step. The shifted partial remainder is WIDTH+1 bits wide
    // so divisors with the MSB set compare correctly. When there is no borrow
    // the true difference is below the divisor, so its low WIDTH bits are exact.
    logic [WIDTH:0]       shifted;
    logic                 borrow;
    logic [WIDTH-1:0]     diff_lo;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 abort;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign borrow  = (shifted < {1'b0, dsr_q});
    assign diff_lo = shifted[WIDTH-1:0] - dsr_q;

    // Quotient takes the XOR of the operand signs, remainder takes the
    // dividend's sign. The most negative dividend over -1 wraps naturally.
    assign quo_fix = neg_quo_q ? (~quo_q + ONE) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + ONE) : rem_q;

    assign abort = annul_i || !start_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = 1'b0;
        result_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_d     = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
                    dsr_d     = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                // quotient and remainder were cleared on accept
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_END;
                end
            end

            S_ON: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    quo_d = {quo_q[WIDTH-2:0], ~borrow};
                    rem_d = borrow ? shifted[WIDTH-1:0] : diff_lo;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_END;
                    end
                end
            end

            S_END: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. Drivers issue divisions and push the
//   reference {remainder, quotient} into exp_q; a monitor on the falling edge
//   pops and compares on each rising ready_o, checks the result stays stable
//   while ready_o is held, and checks result_o is zero whenever ready_o is low.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic [1:0]         dbg_state_o;

    logic [2*WIDTH-1:0] exp_q[$];
    int                 n_checks = 0;
    int                 n_errors = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [2*WIDTH-1:0] ref_div(input bit sgn, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        longint sa, sb, q, r;
        logic [WIDTH-1:0] uq, ur;
        if (b == 0) return '0;
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[WIDTH-1:0], q[WIDTH-1:0]};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check64(input string name, input logic [2*WIDTH-1:0] act,
                           input logic [2*WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic               prev_ready = 1'b0;
    logic [2*WIDTH-1:0] held       = '0;

    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ready: got result %h with nothing expected", result_o);
            end else begin
                held = exp_q.pop_front();
                check64("result", result_o, held);
            end
        end else if (ready_o) begin
            check64("result_hold", result_o, held);
        end else begin
            check64("result_zero_when_not_ready", result_o, '0);
        end
        prev_ready = ready_o;
    end

    // ---------------- driver tasks ----------------
    // Counts edges after the accepting edge until ready_o is observed.
    task automatic wait_ready(input int lat, output bit seen);
        int n;
        n    = 0;
        seen = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        check_int("latency", seen ? n : -1, lat);
    endtask

    // end_mode: 0 = drop start_i, 1 = annul while in END, 2 = async reset while in END
    task automatic run_div(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int hold, input int end_mode);
        bit seen;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_q.push_back(ref_div(sgn, a, b));
        wait_ready((b == 0) ? 2 : WIDTH + 1, seen);
        repeat (hold) @(negedge clk);
        if (end_mode == 2) begin
            #2 rst = 1'b0;
            #1;
            check_int("async_reset_end_ready", int'(ready_o), 0);
            check64("async_reset_end_result", result_o, '0);
            start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else if (end_mode == 1) begin
            annul_i = 1'b1;
            @(negedge clk);
            check_int("annul_end_ready", int'(ready_o), 0);
            check_int("annul_end_state", int'(dbg_state_o), 0);
            annul_i = 1'b0;
            start_i = 1'b0;
        end else begin
            start_i = 1'b0;
            @(negedge clk);
            check_int("ready_drop", int'(ready_o), 0);
            check_int("idle_after_drop", int'(dbg_state_o), 0);
        end
        // leave queue clean if ready never arrived so later pops stay aligned
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] a, b;
        int               r;

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        repeat (2) @(negedge clk);
        check_int("reset_ready", int'(ready_o), 0);
        check64("reset_result", result_o, '0);
        check_int("reset_state", int'(dbg_state_o), 0);
        rst = 1'b1;
        @(negedge clk);

        // basic unsigned, held a few cycles
        run_div(1'b0, 32'd100, 32'd7, 3, 0);
        // signed sign rules
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
        // divide by zero, both modes
        run_div(1'b0, 32'd1234, 32'd0, 2, 0);
        run_div(1'b1, 32'hDEAD_BEEF, 32'd0, 1, 0);

        // annul in the middle of ON
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        check_int("on_before_annul", int'(dbg_state_o), 2);
        annul_i = 1'b1;
        @(negedge clk);
        check_int("annul_on_state", int'(dbg_state_o), 0);
        check_int("annul_on_ready", int'(ready_o), 0);
        annul_i = 1'b0;
        start_i = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, 1, 0);

        // wrap and large operands
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);

        // start with annul in IDLE is ignored
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd1;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_int("annul_start_idle", int'(dbg_state_o), 0);
        end
        start_i = 1'b0;
        annul_i = 1'b0;

        // annul while the result is presented
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1, 1);

        // async reset in the middle of ON
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_int("async_reset_on_state", int'(dbg_state_o), 0);
        check_int("async_reset_on_ready", int'(ready_o), 0);
        check64("async_reset_on_result", result_o, '0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 2, 0);

        // async reset while the result is presented
        run_div(1'b0, 32'd77, 32'd5, 1, 2);

        // randomized divisions
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            r = $urandom_range(0, 9);
            if (r == 0)      b = '0;
            else if (r <= 3) b = $urandom_range(1, 20);
            else if (r == 4) b = 32'hFFFF_FFFF;
            else             b = $urandom;
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
